wb_arbiter: RTL

Writeback arbiter for the RISC-V core; sits directly upstream of the register file and owns its single write port. It merges single-cycle ALU results with long-latency memory/load results. ALU results have priority. Memory results are buffered in a small FIFO, and an anti-starvation counter briefly back-pressures the ALU path. Writes to x0 are dropped here, so the register file never sees them.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 59 +++++
 rtl/wb_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions for the writeback path.
// Provides the default datapath widths used as parameter defaults and the
// writeback request record {rd, data} carried from producers to the register file.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // x0 is hard-wired to zero; any write aimed at it is meaningless.
  function automatic logic isZeroReg(input logic [REG_ADDR_W-1:0] rd);
    return rd == '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering memory results ahead of the writeback port.
// Latency: an entry pushed at edge N is visible at popData after edge N.
// Backpressure: full is driven from the registered count; the caller must not push when full
// or pop when empty.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset (empties the FIFO)
//   push, pushData  - write an entry at the tail
//   pop, popData    - head entry (combinational read) and its removal
//   full, empty     - registered occupancy flags
//   count           - number of entries currently held
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;

  // DEPTH is a power of two, so pointers wrap naturally at their width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushData;
  end

  assign popData = mem[rdPtr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: owns the single register-file write port, merging ALU results
// (priority) with buffered memory results; writes to x0 are consumed and dropped.
// Latency: ALU 1 cycle to registered outputs; memory >= 2 cycles (enqueue, then pop).
// Backpressure: mem_ready low when the FIFO is full; alu_ready low for one cycle when
// the FIFO head has waited STARVE_LIMIT cycles.
// Ports:
//   clk, reset                           - clock, asynchronous active-low reset
//   alu_valid/alu_ready/alu_rd/alu_data  - ALU result handshake
//   mem_valid/mem_ready/mem_rd/mem_data  - memory result handshake
//   reg_write/write_reg/write_data       - registered register-file write port
//   fifo_count                           - memory results currently buffered
module wb_arbiter
  import riscv_pkg::*;
#(
  parameter int DATA_W       = XLEN,
  parameter int ADDR_W       = REG_ADDR_W,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [ADDR_W-1:0]             alu_rd,
  input  logic [DATA_W-1:0]             alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [ADDR_W-1:0]             mem_rd,
  input  logic [DATA_W-1:0]             mem_data,
  output logic                          reg_write,
  output logic [ADDR_W-1:0]             write_reg,
  output logic [DATA_W-1:0]             write_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t                head;
  req_t                pushReq;
  req_t                wrReq;
  logic                fifoFull;
  logic                fifoEmpty;
  logic                push;
  logic                pop;
  logic                wrEn;
  logic                aluXfer;
  logic                memXfer;
  logic                starved;
  logic [STARVE_W-1:0] starveCnt;

  assign starved   = (starveCnt == STARVE_W'(STARVE_LIMIT));
  assign alu_ready = !starved;
  assign mem_ready = !fifoFull;

  assign aluXfer = alu_valid && alu_ready;
  assign memXfer = mem_valid && mem_ready;

  // A memory result for x0 completes its handshake but never occupies a slot.
  assign push    = memXfer && (mem_rd != '0);
  assign pushReq = '{rd: mem_rd, data: mem_data};

  wb_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pushData (pushReq),
    .pop      (pop),
    .popData  (head),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifo_count)
  );

  // Write selection. A starved head wins outright (alu_ready is already low, so no
  // ALU transfer can be lost). An ALU transfer to x0 is consumed without a write,
  // which frees the port for the FIFO head in the same cycle.
  always_comb begin
    pop   = 1'b0;
    wrEn  = 1'b0;
    wrReq = head;
    if (starved && !fifoEmpty) begin
      pop  = 1'b1;
      wrEn = 1'b1;
    end else if (aluXfer && (alu_rd != '0)) begin
      wrEn  = 1'b1;
      wrReq = '{rd: alu_rd, data: alu_data};
    end else if (!fifoEmpty) begin
      pop  = 1'b1;
      wrEn = 1'b1;
    end
  end

  // Counts cycles the current head has been passed over; saturates so alu_ready
  // stays low until the forced pop clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starveCnt <= '0;
    end else if (pop || fifoEmpty) begin
      starveCnt <= '0;
    end else if (!starved) begin
      starveCnt <= starveCnt + STARVE_W'(1);
    end
  end

  // Address/data only move on a write; reg_write alone qualifies them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      reg_write <= wrEn;
      if (wrEn) begin
        write_reg  <= wrReq.rd;
        write_data <= wrReq.data;
      end
    end
  end

endmodule
